// File: rtl/exec_issue_queue.sv
// exec_issue_queue
// In-order issue queue between dispatch and a single execution unit.
// Each entry carries two source operands (data, valid flag, producer tag)
// and an opaque payload. Operands wake up from the common data bus (CDB).
// Only the head entry may issue, and only once both of its operands are
// valid.
//
// Optional feature macro: EXEC_IQ_CDB_WRITE_BYPASS_EN
//   When it is defined, an operand that is written while its producer tag is
//   being broadcast on the CDB is captured with the broadcast data. When it
//   is not defined, the operand is stored exactly as presented, and dispatch
//   must never present a tag that is being broadcast in the same cycle.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid & ready are both 1. in_ready and out_valid depend only on registered
// state plus flush and i_rst_n, so no combinational path runs from in_valid or
// out_ready. A producer holding valid with ready low must keep its data
// stable. The queue keeps the head stable while out_valid & !out_ready.
module exec_issue_queue #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32,
    parameter int PAYLOAD_W = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    flush,
    // dispatch side
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PAYLOAD_W-1:0]    in_payload,
    input  logic [DATA_W-1:0]       in_rs1_data,
    input  logic [DATA_W-1:0]       in_rs2_data,
    input  logic                    in_rs1_valid,
    input  logic                    in_rs2_valid,
    input  logic [TAG_W-1:0]        in_rs1_tag,
    input  logic [TAG_W-1:0]        in_rs2_tag,
    // common data bus
    input  logic                    cdb_valid,
    input  logic [TAG_W-1:0]        cdb_tag,
    input  logic [DATA_W-1:0]       cdb_data,
    // issue side
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PAYLOAD_W-1:0]    out_payload,
    output logic [DATA_W-1:0]       out_rs1_data,
    output logic [DATA_W-1:0]       out_rs2_data,
    // status
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    // Pointers carry one extra wrap bit so that full and empty are distinct
    // states even though both have equal low (index) bits.
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]     r_wp;
    logic [PTR_W-1:0]     r_rp;
    logic [DEPTH-1:0]     r_occ;
    logic [DEPTH-1:0]     r_rs1_v;
    logic [DEPTH-1:0]     r_rs2_v;
    logic [TAG_W-1:0]     r_rs1_tag  [DEPTH];
    logic [TAG_W-1:0]     r_rs2_tag  [DEPTH];
    logic [DATA_W-1:0]    r_rs1_data [DEPTH];
    logic [DATA_W-1:0]    r_rs2_data [DEPTH];
    logic [PAYLOAD_W-1:0] r_payload  [DEPTH];

    // ------------------------------------------------------------------
    // Derived signals
    // ------------------------------------------------------------------
    logic [PTR_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic [IDX_W-1:0]  w_head_idx;
    logic [IDX_W-1:0]  w_tail_idx;
    logic              w_head_ready;
    logic              w_push;
    logic              w_pop;
    logic [DEPTH-1:0]  w_wake1;
    logic [DEPTH-1:0]  w_wake2;
    logic              w_byp1;
    logic              w_byp2;
    logic              w_in_rs1_v;
    logic              w_in_rs2_v;
    logic [DATA_W-1:0] w_in_rs1_data;
    logic [DATA_W-1:0] w_in_rs2_data;

    // Modulo difference of the wrapping pointers is the occupancy.
    assign w_count    = r_wp - r_rp;
    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == FULL_CNT);
    assign w_head_idx = r_rp[IDX_W-1:0];
    assign w_tail_idx = r_wp[IDX_W-1:0];

    assign count = w_count;
    assign empty = w_empty;
    assign full  = w_full;

    // A write is refused whenever the queue is full, even if the head pops in
    // the same cycle. That keeps the write slot and the pop slot distinct and
    // keeps in_ready independent of out_ready.
    assign in_ready = i_rst_n & ~flush & ~w_full;
    assign w_push   = in_valid & in_ready;

    // Issue eligibility only looks at registered operand state. An operand
    // woken this cycle therefore issues at the earliest in the next cycle.
    assign w_head_ready = ~w_empty & r_rs1_v[w_head_idx] & r_rs2_v[w_head_idx];
    assign out_valid    = w_head_ready & ~flush;
    assign w_pop        = out_valid & out_ready;

    // Outputs are forced to zero while nothing is issuable, so that stale
    // slot contents never leak downstream.
    assign out_payload  = out_valid ? r_payload[w_head_idx]  : '0;
    assign out_rs1_data = out_valid ? r_rs1_data[w_head_idx] : '0;
    assign out_rs2_data = out_valid ? r_rs2_data[w_head_idx] : '0;

    // Same-cycle CDB capture for the entry being written.
`ifdef EXEC_IQ_CDB_WRITE_BYPASS_EN
    assign w_byp1 = cdb_valid & ~in_rs1_valid & (in_rs1_tag == cdb_tag);
    assign w_byp2 = cdb_valid & ~in_rs2_valid & (in_rs2_tag == cdb_tag);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign w_in_rs1_v    = in_rs1_valid | w_byp1;
    assign w_in_rs2_v    = in_rs2_valid | w_byp2;
    assign w_in_rs1_data = w_byp1 ? cdb_data : in_rs1_data;
    assign w_in_rs2_data = w_byp2 ? cdb_data : in_rs2_data;

    // Per-entry, per-operand CDB tag match on occupied, still-waiting operands.
    always_comb begin
        w_wake1 = '0;
        w_wake2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wake1[i] = cdb_valid & ~flush & r_occ[i] & ~r_rs1_v[i]
                         & (r_rs1_tag[i] == cdb_tag);
            w_wake2[i] = cdb_valid & ~flush & r_occ[i] & ~r_rs2_v[i]
                         & (r_rs2_tag[i] == cdb_tag);
        end
    end

    // ------------------------------------------------------------------
    // Control state: pointers, occupied bits, operand valid bits.
    // Flush takes priority over push, pop and wakeup.
    // ------------------------------------------------------------------
    // Update pointers and per-entry flags on push, pop, wakeup and flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_occ   <= '0;
            r_rs1_v <= '0;
            r_rs2_v <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_occ   <= '0;
            r_rs1_v <= '0;
            r_rs2_v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wake1[i]) r_rs1_v[i] <= 1'b1;
                if (w_wake2[i]) r_rs2_v[i] <= 1'b1;
            end
            if (w_pop) begin
                r_occ[w_head_idx] <= 1'b0;
                r_rp              <= r_rp + PTR_W'(1);
            end
            // The write slot is never occupied, so neither a wakeup nor a pop
            // can target it in the same cycle.
            if (w_push) begin
                r_occ[w_tail_idx]   <= 1'b1;
                r_rs1_v[w_tail_idx] <= w_in_rs1_v;
                r_rs2_v[w_tail_idx] <= w_in_rs2_v;
                r_wp                <= r_wp + PTR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry contents. These are only observed through the valid/occupied
    // flags and the gated outputs, so they carry no reset.
    // ------------------------------------------------------------------
    // Capture dispatched entries and CDB data into the entry storage.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wake1[i]) r_rs1_data[i] <= cdb_data;
            if (w_wake2[i]) r_rs2_data[i] <= cdb_data;
        end
        if (w_push) begin
            r_payload[w_tail_idx]  <= in_payload;
            r_rs1_tag[w_tail_idx]  <= in_rs1_tag;
            r_rs2_tag[w_tail_idx]  <= in_rs2_tag;
            r_rs1_data[w_tail_idx] <= w_in_rs1_data;
            r_rs2_data[w_tail_idx] <= w_in_rs2_data;
        end
    end

endmodule

// File: tb/tb_exec_issue_queue.sv
// Testbench for exec_issue_queue (DEPTH=4, TAG_W=6, DATA_W=32, PAYLOAD_W=64).
// Table-driven fill/drain vectors plus hand-written multi-cycle sequences.
// A payload/operand scoreboard is filled when a write is expected to be
// accepted and drained whenever the DUT issues.
module tb_exec_issue_queue;

    localparam int DEPTH     = 4;
    localparam int TAG_W     = 6;
    localparam int DATA_W    = 32;
    localparam int PAYLOAD_W = 64;
    localparam int CW        = 3;
    localparam int EXP_W     = PAYLOAD_W + 2 * DATA_W;

    // ---------------- clock / reset ----------------
    logic i_clk;
    logic i_rst_n;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- DUT signals ----------------
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [DATA_W-1:0]    in_rs1_data;
    logic [DATA_W-1:0]    in_rs2_data;
    logic                 in_rs1_valid;
    logic                 in_rs2_valid;
    logic [TAG_W-1:0]     in_rs1_tag;
    logic [TAG_W-1:0]     in_rs2_tag;
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;
    logic [DATA_W-1:0]    cdb_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [DATA_W-1:0]    out_rs1_data;
    logic [DATA_W-1:0]    out_rs2_data;
    logic [CW-1:0]        count;
    logic                 empty;
    logic                 full;

    exec_issue_queue #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .PAYLOAD_W(PAYLOAD_W)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_payload(in_payload),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rs1_valid(in_rs1_valid), .in_rs2_valid(in_rs2_valid),
        .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .count(count), .empty(empty), .full(full)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [EXP_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] e_rs1;
    logic [DATA_W-1:0] e_rs2;

    task automatic check(input string name, input logic [EXP_W-1:0] act,
                         input logic [EXP_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    // One clock: check occupancy/in_ready against the model, compare an issued
    // entry against the queue head, then advance the model past the edge.
    task automatic cycle();
        logic             do_pop;
        logic             do_push;
        logic [EXP_W-1:0] push_val;
        check("count", count, exp_q.size());
        check("in_ready", in_ready, (exp_q.size() < DEPTH) && !flush);
        do_pop  = out_valid && out_ready && !flush;
        do_push = in_valid && !flush && (exp_q.size() < DEPTH);
        push_val = {in_payload, e_rs1, e_rs2};
        if (do_pop) begin
            if (exp_q.size() == 0)
                check("issue_unexpected", {out_payload, out_rs1_data, out_rs2_data}, '0);
            else
                check("issue_entry", {out_payload, out_rs1_data, out_rs2_data}, exp_q[0]);
        end
        @(posedge i_clk);
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (do_pop && exp_q.size() > 0) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(push_val);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic put_entry(input logic [PAYLOAD_W-1:0] pl,
                             input logic v1, input logic [TAG_W-1:0] t1,
                             input logic [DATA_W-1:0] d1,
                             input logic v2, input logic [TAG_W-1:0] t2,
                             input logic [DATA_W-1:0] d2,
                             input logic [DATA_W-1:0] x1,
                             input logic [DATA_W-1:0] x2);
        in_valid     = 1'b1;
        in_payload   = pl;
        in_rs1_valid = v1;
        in_rs1_tag   = t1;
        in_rs1_data  = d1;
        in_rs2_valid = v2;
        in_rs2_tag   = t2;
        in_rs2_data  = d2;
        e_rs1        = x1;
        e_rs2        = x2;
    endtask

    task automatic put_ready(input logic [PAYLOAD_W-1:0] pl);
        put_entry(pl, 1'b1, 6'h00, {16'hA000, pl[15:0]},
                  1'b1, 6'h00, {16'hB000, pl[15:0]},
                  {16'hA000, pl[15:0]}, {16'hB000, pl[15:0]});
    endtask

    task automatic cdb_drive(input logic v, input logic [TAG_W-1:0] t,
                             input logic [DATA_W-1:0] d);
        cdb_valid = v;
        cdb_tag   = t;
        cdb_data  = d;
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic                 iv;
        logic                 ordy;
        logic [PAYLOAD_W-1:0] pl;
        logic [CW-1:0]        cnt;
        logic                 full;
        logic                 empty;
        logic                 ir;
        logic                 ov;
    } vec_t;

    vec_t vt[10];

    initial begin
        //         iv    ordy  payload     cnt   full  empty ir    ov
        vt[0] = '{1'b1, 1'b0, 64'h100, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[1] = '{1'b1, 1'b0, 64'h101, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[2] = '{1'b1, 1'b0, 64'h102, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[3] = '{1'b1, 1'b0, 64'h103, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[4] = '{1'b1, 1'b0, 64'h1FF, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[5] = '{1'b1, 1'b1, 64'h1FE, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[6] = '{1'b0, 1'b1, 64'h0,   3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[7] = '{1'b0, 1'b1, 64'h0,   3'd2, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[8] = '{1'b0, 1'b1, 64'h0,   3'd1, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[9] = '{1'b0, 1'b0, 64'h0,   3'd0, 1'b0, 1'b1, 1'b1, 1'b0};

        // reset state
        i_rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_payload = '0; in_rs1_data = '0; in_rs2_data = '0;
        in_rs1_valid = 1'b0; in_rs2_valid = 1'b0;
        in_rs1_tag = '0; in_rs2_tag = '0;
        cdb_drive(1'b0, '0, '0);
        e_rs1 = '0; e_rs2 = '0;
        #2;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", {out_payload, out_rs1_data, out_rs2_data}, '0);
        #10 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // fill to full, refused writes, drain in order
        for (int i = 0; i < 10; i++) begin
            if (vt[i].iv) put_ready(vt[i].pl);
            else in_valid = 1'b0;
            out_ready = vt[i].ordy;
            settle();
            check($sformatf("vec%0d_count", i), count, vt[i].cnt);
            check($sformatf("vec%0d_full", i), full, vt[i].full);
            check($sformatf("vec%0d_empty", i), empty, vt[i].empty);
            check($sformatf("vec%0d_in_ready", i), in_ready, vt[i].ir);
            check($sformatf("vec%0d_out_valid", i), out_valid, vt[i].ov);
            cycle();
        end
        in_valid = 1'b0;

        // wakeup on the head: wrong tag ignored, no same-cycle issue
        out_ready = 1'b0;
        put_entry(64'hA, 1'b0, 6'h05, 32'h0, 1'b1, 6'h00, 32'h22, 32'hDEADBEEF, 32'h22);
        settle();
        cycle();
        in_valid = 1'b0;
        cdb_drive(1'b1, 6'h06, 32'h66);
        settle();
        check("wk_wait_ov", out_valid, 0);
        check("wk_gated_payload", out_payload, 0);
        cycle();
        cdb_drive(1'b1, 6'h05, 32'hDEADBEEF);
        settle();
        check("wk_tag6_no_wake", out_valid, 0);
        cycle();
        cdb_drive(1'b0, '0, '0);
        settle();
        check("wk_ov_next", out_valid, 1);
        check("wk_rs1_data", out_rs1_data, 32'hDEADBEEF);
        out_ready = 1'b1;
        cycle();

        // head blocking: ready entry behind a waiting head must wait
        put_entry(64'hB0, 1'b0, 6'h0A, 32'h0, 1'b1, 6'h00, 32'h33, 32'hAAAA0001, 32'h33);
        settle();
        cycle();
        put_ready(64'hB1);
        settle();
        check("hb_ov0_a", out_valid, 0);
        cycle();
        in_valid = 1'b0;
        settle();
        check("hb_ov0_b", out_valid, 0);
        check("hb_count", count, 2);
        cycle();
        cdb_drive(1'b1, 6'h0A, 32'hAAAA0001);
        settle();
        check("hb_ov0_bcast", out_valid, 0);
        cycle();
        cdb_drive(1'b0, '0, '0);
        settle();
        check("hb_head_issue", out_valid, 1);
        cycle();
        settle();
        check("hb_second_issue", out_valid, 1);
        cycle();
        out_ready = 1'b0;
        settle();
        check("hb_empty", empty, 1);

        // wrap and concurrency: steady push+pop with two entries in flight
        put_ready(64'h300);
        settle();
        cycle();
        put_ready(64'h301);
        settle();
        cycle();
        for (int i = 0; i < 20; i++) begin
            put_ready(64'h310 + 64'(i));
            out_ready = 1'b1;
            settle();
            check($sformatf("wrap%0d_count", i), count, 2);
            check($sformatf("wrap%0d_ov", i), out_valid, 1);
            cycle();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 8 && exp_q.size() > 0; k++) begin
            settle();
            cycle();
        end
        settle();
        check("wrap_drained", empty, 1);

        // flush with pending entries and a concurrent write
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put_ready(64'h400 + 64'(i));
            settle();
            cycle();
        end
        put_ready(64'h4FF);
        flush = 1'b1;
        settle();
        check("fl_in_ready", in_ready, 0);
        check("fl_out_valid", out_valid, 0);
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        settle();
        check("fl_count", count, 0);
        check("fl_empty", empty, 1);
        check("fl_ov", out_valid, 0);
        out_ready = 1'b1;
        cycle();
        settle();
        check("fl_ov_stays0", out_valid, 0);
        cycle();
        put_ready(64'h410);
        settle();
        cycle();
        in_valid = 1'b0;
        settle();
        check("fl_new_ov", out_valid, 1);
        cycle();
        out_ready = 1'b0;

        // asynchronous reset in the middle of operation
        put_ready(64'h500);
        settle();
        cycle();
        put_ready(64'h501);
        settle();
        cycle();
        in_valid = 1'b0;
        settle();
        check("ar_count_before", count, 2);
        #2 i_rst_n = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_empty", empty, 1);
        check("ar_in_ready", in_ready, 0);
        check("ar_ov", out_valid, 0);
        exp_q.delete();
        @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // same-cycle dispatch and broadcast of the rs2 producer tag
        out_ready = 1'b0;
        cdb_drive(1'b1, 6'h11, 32'h1234);
`ifdef EXEC_IQ_CDB_WRITE_BYPASS_EN
        put_entry(64'h600, 1'b1, 6'h00, 32'h61, 1'b0, 6'h11, 32'hBAD, 32'h61, 32'h1234);
`else
        put_entry(64'h600, 1'b1, 6'h00, 32'h61, 1'b0, 6'h11, 32'hBAD, 32'h61, 32'h5678);
`endif
        settle();
        check("byp_ov_empty", out_valid, 0);
        cycle();
        in_valid = 1'b0;
        cdb_drive(1'b0, '0, '0);
        settle();
`ifdef EXEC_IQ_CDB_WRITE_BYPASS_EN
        check("byp_ov", out_valid, 1);
        check("byp_rs2", out_rs2_data, 32'h1234);
        out_ready = 1'b1;
        cycle();
`else
        check("nobyp_stall_a", out_valid, 0);
        cycle();
        settle();
        check("nobyp_stall_b", out_valid, 0);
        cdb_drive(1'b1, 6'h11, 32'h5678);
        settle();
        check("nobyp_bcast_ov", out_valid, 0);
        cycle();
        cdb_drive(1'b0, '0, '0);
        out_ready = 1'b1;
        settle();
        check("nobyp_ov", out_valid, 1);
        cycle();
`endif
        out_ready = 1'b0;
        settle();
        check("end_empty", empty, 1);
        check("end_scoreboard", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exec_issue_queue.md
# exec_issue_queue

In-order issue queue with common-data-bus (CDB) operand wakeup, placed between dispatch and one execution unit (load/store, multiply or divide). Each entry holds two source operands, each with data, a valid flag and a producer tag, plus an opaque payload. Only the head entry may issue, and only when both of its operands are valid. Compared with the fixed four-entry queue, this block adds parametrised depth and widths, ready/valid backpressure on both sides, an occupancy count and an optional same-cycle CDB capture on write.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- TAG_W, 6, CDB/producer tag width
- DATA_W, 32, operand data width
- PAYLOAD_W, 64, opaque per-entry payload width (opcode, immediate, destination tag, ...)

- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all entries (mispredict recovery)
- in_valid  in  1  dispatch presents an entry
- in_ready  out  1  queue accepts the entry this cycle
- in_payload  in  PAYLOAD_W  entry payload
- in_rs1_data / in_rs2_data  in  DATA_W  operand data, meaningful when the matching valid is 1
- in_rs1_valid / in_rs2_valid  in  1  operand already available
- in_rs1_tag / in_rs2_tag  in  TAG_W  producer tag, meaningful when the matching valid is 0
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  DATA_W  broadcast data
- out_valid  out  1  head entry is ready to issue
- out_ready  in  1  execution unit accepts the head
- out_payload  out  PAYLOAD_W  head payload
- out_rs1_data / out_rs2_data  out  DATA_W  head operand data
- count  out  $clog2(DEPTH)+1  occupied entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Storage is a circular buffer. The write pointer wp and read pointer rp are each $clog2(DEPTH)+1 bits and wrap naturally. count = wp - rp (modulo arithmetic). Entries are indexed by the pointer's low bits.
- Each entry has an occupied bit. Reset and flush clear every occupied bit. Wakeup ignores unoccupied entries.
- Write handshake:
  - in_ready = i_rst_n & !flush & !full.
  - On in_valid & in_ready, store the entry at wp, set its occupied bit, and increment wp.
  - A write is refused when full, even if a pop occurs in the same cycle.
- Issue handshake:
  - out_valid = !empty & !flush & head.rs1_valid & head.rs2_valid.
  - out_* are driven from the head entry. While out_valid is 0, out_payload and the operand data outputs are driven to 0.
  - On out_valid & out_ready: clear the head's occupied bit and increment rp.
  - The head is held stable while out_valid & !out_ready.
- Wakeup: on cdb_valid, for every occupied entry and each operand independently, when the operand valid is 0 and its tag equals cdb_tag, load cdb_data and set the operand valid. Several entries or both operands may wake in one cycle.
- Simultaneous write and pop in one cycle: both take effect and count is unchanged. Write and pop never target the same slot, because writes are refused when full.
- Flush has priority over write, pop and wakeup. The next state is wp = rp = 0 with all entries unoccupied.
- Reset asserted mid-operation immediately (asynchronously) returns the block to its reset state.

## Timing
- Reset values:
  - wp = rp = 0; all occupied bits and operand valid bits = 0.
  - count = 0, empty = 1, full = 0, out_valid = 0, out data = 0.
  - in_ready = 0 while i_rst_n is low.
- Write-to-issue latency is at least 1 cycle: an entry written at edge N with both operands valid raises out_valid during cycle N+1. There is no input-to-output bypass when empty.
- Wakeup latency is 1 cycle: a CDB match at edge N makes the operand valid from cycle N+1. The head does not issue combinationally in the cycle of its CDB broadcast.
- in_ready, out_valid, empty, full and count are combinational from registered state plus flush and i_rst_n. There is no combinational path from in_valid or out_ready.

## Configuration
- EXEC_IQ_CDB_WRITE_BYPASS_EN defined: while an entry is being written, each operand with in_rsX_valid = 0 and in_rsX_tag == cdb_tag under cdb_valid is stored with cdb_data and valid = 1. This closes the same-cycle dispatch/broadcast hole.
- Not defined: the operand is stored exactly as presented. Dispatch guarantees that it never presents a tag being broadcast in the same cycle.

## Test plan
- Reset then fill: with DEPTH=4, write 4 entries with both operands valid and out_ready = 0 → full = 1, in_ready = 0, count = 4. A fifth in_valid is dropped. Then out_ready = 1 → payloads issue in order, one per cycle, and end with empty = 1.
- Wakeup: write entry A with rs1 tag 0x05 invalid and rs2 valid. Drive cdb_valid, tag 0x05, data 0xDEADBEEF at edge N → out_valid rises in cycle N+1 with out_rs1_data = 0xDEADBEEF. A broadcast with tag 0x06 causes no change.
- Head blocking: the head waits on tag 0x0A while entry 2 is fully valid → out_valid stays 0. Broadcasting 0x0A issues the head, then entry 2 issues the following cycle.
- Wrap and concurrency: run 20 cycles with in_valid = out_ready = 1 and valid operands → count stays constant. The pointers wrap past 2·DEPTH and no payload is lost or duplicated.
- Flush: with 3 entries pending, assert flush while in_valid = 1 → in_ready = 0 and out_valid = 0 that cycle. Next cycle count = 0 and empty = 1, and the flushed entries never appear.
- Write bypass: write an entry with rs2 tag 0x11 invalid while cdb_valid with tag 0x11 and data 0x1234 are driven in the same cycle → with the macro, out_valid rises next cycle with out_rs2_data = 0x1234. Without the macro, the entry stalls.
